// File: rtl/alu_ser_pkg.sv
// Shared types and constants for the ALU result serializer.
//   state_t    : serializer FSM state (IDLE / SEND)
//   BYTE_W     : width of one output byte
//   num_bytes(): bytes needed to carry a result of the given width
package alu_ser_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  function automatic int num_bytes(input int width);
    return (width + BYTE_W - 1) / BYTE_W;
  endfunction

endpackage

// File: rtl/alu_result_serializer_if.sv
// Bus between the ALU result producer / UART TX consumer / system controller
// and the serializer.
//   Result_Data, Result_Valid : registered ALU result and its one-cycle pulse
//   Byte_Data, Byte_Valid     : byte stream towards UART TX
//   Byte_Ready                : UART TX accepts the current byte
//   Busy, Overflow            : status towards the system controller
//   Clear_Ovf                 : one-cycle pulse clearing Overflow
// The slave modport is the serializer; the master modport is its environment.
interface alu_ser_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] Result_Data;
  logic             Result_Valid;
  logic [7:0]       Byte_Data;
  logic             Byte_Valid;
  logic             Byte_Ready;
  logic             Busy;
  logic             Overflow;
  logic             Clear_Ovf;

  modport master (
    output Result_Data, Result_Valid, Byte_Ready, Clear_Ovf,
    input  Byte_Data, Byte_Valid, Busy, Overflow
  );

  modport slave (
    input  Result_Data, Result_Valid, Byte_Ready, Clear_Ovf,
    output Byte_Data, Byte_Valid, Busy, Overflow
  );
endinterface

// File: rtl/result_fifo.sv
// First-word fall-through result FIFO.
//   i_clk, i_rst       : clock, asynchronous active-high reset
//   i_wr_en, i_wr_data : write port; accepted when not full, or when full
//                        and a read happens in the same cycle
//   i_rd_en            : pop the head entry (ignored when empty)
//   o_rd_data          : head entry, valid whenever o_empty=0
//   o_full, o_empty    : occupancy flags
module result_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_rd_data = r_mem[r_rd_ptr];

  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign w_wr = i_wr_en && (!o_full || i_rd_en);
  assign w_rd = i_rd_en && !o_empty;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage has no reset; the pointers/count define which entries are
  // meaningful, so clearing the array would only cost reset routing.
  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/alu_result_serializer.sv
// Buffers ALU results and streams each one out as bytes, LSB first, over a
// valid/ready handshake.
//   CLK : clock, rising edge
//   RST : asynchronous active-high reset; discards buffered and partial results
//   bus : alu_ser_if slave -- result input, byte output, Busy/Overflow status
// Results are zero-padded to a whole number of bytes. The next buffered result
// is loaded on the final handshake of the current one, so consecutive results
// stream without a bubble.
module alu_result_serializer
  import alu_ser_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic  CLK,
  input  logic  RST,
  alu_ser_if.slave bus
);
  localparam int NB      = num_bytes(WIDTH);
  localparam int SHIFT_W = NB * BYTE_W;
  localparam int IDX_W   = (NB > 1) ? $clog2(NB) : 1;

  state_t             r_state;
  state_t             w_next_state;
  logic [SHIFT_W-1:0] r_shift;
  logic [IDX_W-1:0]   r_idx;
  logic               r_ovf;

  logic [WIDTH-1:0]   w_head;
  logic               w_full;
  logic               w_empty;
  logic               w_hs;
  logic               w_last;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;

  assign w_hs   = (r_state == SEND) && bus.Byte_Ready;
  assign w_last = (r_idx == IDX_W'(NB - 1));
  // Pop from IDLE, or on the last byte's handshake for back-to-back streaming.
  assign w_pop  = !w_empty && ((r_state == IDLE) || (w_hs && w_last));
  assign w_push = bus.Result_Valid && (!w_full || w_pop);
  assign w_drop = bus.Result_Valid && w_full && !w_pop;

  result_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk     (CLK),
    .i_rst     (RST),
    .i_wr_en   (w_push),
    .i_wr_data (bus.Result_Data),
    .i_rd_en   (w_pop),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: every always_comb output gets a default first so no path through
  // the block leaves it unassigned (which would infer a latch).
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (!w_empty) w_next_state = SEND;
      SEND:    if (w_hs && w_last && w_empty) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.Byte_Valid = 1'b0;
    bus.Byte_Data  = '0;
    if (r_state == SEND) begin
      bus.Byte_Valid = 1'b1;
      bus.Byte_Data  = r_shift[r_idx*BYTE_W +: BYTE_W];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_shift <= '0;
      r_idx   <= '0;
    end else if (w_pop) begin
      r_shift <= SHIFT_W'(w_head);
      r_idx   <= '0;
    end else if (w_hs && !w_last) begin
      r_idx   <= r_idx + 1'b1;
    end
  end

  // A drop in the same cycle as a clear wins, so no overflow is ever lost.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                r_ovf <= 1'b0;
    else if (w_drop)        r_ovf <= 1'b1;
    else if (bus.Clear_Ovf) r_ovf <= 1'b0;
  end

  assign bus.Busy     = !w_empty || (r_state == SEND);
  assign bus.Overflow = r_ovf;

endmodule

// File: tb/tb_alu_result_serializer.sv
// Directed self-checking bench for alu_result_serializer: a WIDTH=16 build
// for the main scenarios and a WIDTH=12 build for zero-padding.
module tb_alu_result_serializer;

  logic CLK;
  logic RST;

  alu_ser_if #(.WIDTH(16)) bus   ();
  alu_ser_if #(.WIDTH(12)) bus12 ();

  alu_result_serializer #(.WIDTH(16), .DEPTH(2)) u_dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  alu_result_serializer #(.WIDTH(12), .DEPTH(2)) u_dut12 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus12.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] got[$];
  int         got_cyc[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse(input logic [15:0] data);
    bus.Result_Data  = data;
    bus.Result_Valid = 1'b1;
    tick();
    bus.Result_Valid = 1'b0;
  endtask

  // Record every byte handshaken during the next 'cycles' edges.
  task automatic collect(input int cycles);
    got.delete();
    got_cyc.delete();
    for (int i = 0; i < cycles; i++) begin
      if (bus.Byte_Valid && bus.Byte_Ready) begin
        got.push_back(bus.Byte_Data);
        got_cyc.push_back(i);
      end
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp3[6];
    logic [7:0] exp4[6];
    exp3 = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33};
    exp4 = '{8'h66, 8'h66, 8'h77, 8'h77, 8'h88, 8'h88};

    RST = 1'b1;
    bus.Result_Data    = '0;
    bus.Result_Valid   = 1'b0;
    bus.Byte_Ready     = 1'b0;
    bus.Clear_Ovf      = 1'b0;
    bus12.Result_Data  = '0;
    bus12.Result_Valid = 1'b0;
    bus12.Byte_Ready   = 1'b0;
    bus12.Clear_Ovf    = 1'b0;

    // Reset state
    #12;
    check("reset_valid", bus.Byte_Valid, 0);
    check("reset_data",  bus.Byte_Data,  0);
    check("reset_busy",  bus.Busy,       0);
    check("reset_ovf",   bus.Overflow,   0);
    tick();
    RST = 1'b0;
    tick();

    // Single result, no backpressure
    bus.Byte_Ready = 1'b1;
    pulse(16'hA5C3);
    check("t1_valid_n",   bus.Byte_Valid, 0);
    check("t1_busy_n",    bus.Busy,       1);
    tick();
    check("t1_valid_n1",  bus.Byte_Valid, 1);
    check("t1_byte0",     bus.Byte_Data,  8'hC3);
    tick();
    check("t1_valid_n2",  bus.Byte_Valid, 1);
    check("t1_byte1",     bus.Byte_Data,  8'hA5);
    tick();
    check("t1_valid_n3",  bus.Byte_Valid, 0);
    check("t1_busy_n3",   bus.Busy,       0);

    // Backpressure hold
    bus.Byte_Ready = 1'b0;
    pulse(16'hA5C3);
    tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t2_hold_valid%0d", i), bus.Byte_Valid, 1);
      check($sformatf("t2_hold_data%0d", i),  bus.Byte_Data,  8'hC3);
      tick();
    end
    bus.Byte_Ready = 1'b1;
    collect(6);
    check("t2_count", got.size(), 2);
    check("t2_b0",    got[0],     8'hC3);
    check("t2_b1",    got[1],     8'hA5);
    check("t2_idle",  bus.Byte_Valid, 0);

    // Back-to-back results and overflow
    bus.Byte_Ready = 1'b0;
    pulse(16'h1111);
    pulse(16'h2222);
    pulse(16'h3333);
    pulse(16'h4444);
    check("t3_ovf_set", bus.Overflow, 1);
    check("t3_busy",    bus.Busy,     1);
    bus.Byte_Ready = 1'b1;
    collect(10);
    check("t3_count", got.size(), 6);
    for (int k = 0; k < 6; k++) check($sformatf("t3_b%0d", k), got[k], exp3[k]);
    check("t3_no_bubble", got_cyc[5] - got_cyc[0], 5);
    check("t3_idle",      bus.Busy,     0);
    check("t3_ovf_held",  bus.Overflow, 1);
    bus.Clear_Ovf = 1'b1;
    tick();
    bus.Clear_Ovf = 1'b0;
    check("t3_ovf_clr", bus.Overflow, 0);

    // FIFO full with a pop on the final byte's handshake
    bus.Byte_Ready = 1'b0;
    pulse(16'h5555);
    pulse(16'h6666);
    pulse(16'h7777);
    check("t4_head", bus.Byte_Data, 8'h55);
    bus.Byte_Ready = 1'b1;
    tick();
    check("t4_last", bus.Byte_Data, 8'h55);
    pulse(16'h8888);
    check("t4_ovf",     bus.Overflow,  0);
    check("t4_next",    bus.Byte_Data, 8'h66);
    collect(10);
    check("t4_count", got.size(), 6);
    for (int k = 0; k < 6; k++) check($sformatf("t4_b%0d", k), got[k], exp4[k]);
    check("t4_ovf_end", bus.Overflow, 0);

    // Overflow set and clear in the same cycle: set wins
    bus.Byte_Ready = 1'b0;
    pulse(16'h0101);
    pulse(16'h0202);
    pulse(16'h0303);
    bus.Clear_Ovf = 1'b1;
    pulse(16'h0404);
    bus.Clear_Ovf = 1'b0;
    check("t5_ovf_prio", bus.Overflow, 1);
    bus.Byte_Ready = 1'b1;
    collect(10);
    check("t5_count", got.size(), 6);
    check("t5_b4",    got[4],     8'h03);

    // Reset mid-transfer (Overflow still set going in)
    pulse(16'hA5C3);
    tick();
    check("t6_byte0", bus.Byte_Data, 8'hC3);
    tick();
    check("t6_byte1", bus.Byte_Data, 8'hA5);
    #1;
    RST = 1'b1;
    #1;
    check("t6_rst_valid", bus.Byte_Valid, 0);
    check("t6_rst_busy",  bus.Busy,       0);
    check("t6_rst_ovf",   bus.Overflow,   0);
    tick();
    tick();
    RST = 1'b0;
    collect(6);
    check("t6_no_bytes", got.size(), 0);
    check("t6_busy",     bus.Busy,   0);

    // WIDTH=12 zero-padding
    bus12.Byte_Ready   = 1'b1;
    bus12.Result_Data  = 12'hABC;
    bus12.Result_Valid = 1'b1;
    tick();
    bus12.Result_Valid = 1'b0;
    tick();
    check("w12_valid0", bus12.Byte_Valid, 1);
    check("w12_byte0",  bus12.Byte_Data,  8'hBC);
    tick();
    check("w12_valid1", bus12.Byte_Valid, 1);
    check("w12_byte1",  bus12.Byte_Data,  8'h0A);
    tick();
    check("w12_idle",   bus12.Byte_Valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
